// File: rtl/radix4_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Sizes are functions of the operand width so every file derives them identically.
package radix4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digits retired per product; one extra digit absorbs the unsigned top bit.
  function automatic int num_digits(input int width);
    return width / 2 + 1;
  endfunction

  function automatic int acc_width(input int width);
    return 2 * width + 2;
  endfunction

  // bits = {y[2i+1], y[2i], y[2i-1]}
  function automatic logic signed [2:0] booth_digit(input logic [2:0] bits);
    logic signed [2:0] d;
    case (bits)
      3'b001, 3'b010: d = 3'sb001;
      3'b011:         d = 3'sb010;
      3'b100:         d = 3'sb110;
      3'b101, 3'b110: d = 3'sb111;
      default:        d = 3'sb000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/radix4_booth_pp.sv
// One radix-4 Booth partial product d*x*4^idx, with optional zeroing of
// the low APPROX_BITS bits of its two's-complement pattern.
module radix4_booth_pp
  import radix4_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4,
  localparam int AW         = acc_width(WIDTH),
  localparam int IW         = $clog2(num_digits(WIDTH))
) (
  input  logic [WIDTH-1:0]  x,
  input  logic signed [2:0] digit,
  input  logic [IW-1:0]     idx,
  input  logic              approx,
  output logic [AW-1:0]     term
);

  localparam logic [AW-1:0] LOW_MASK = (AW'(1) << APPROX_BITS) - AW'(1);

  logic [AW-1:0] mag;
  logic [AW-1:0] base;
  logic [AW-1:0] shifted;

  assign mag = AW'(x);

  always_comb begin
    base = '0;
    case (digit)
      3'b001:  base = mag;
      3'b010:  base = mag << 1;
      3'b111:  base = -mag;
      3'b110:  base = -(mag << 1);
      default: base = '0;
    endcase
  end

  assign shifted = base << {idx, 1'b0};
  assign term    = approx ? (shifted & ~LOW_MASK) : shifted;

endmodule

// File: rtl/radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock behind
// valid/ready handshakes, with a per-transaction exact/approximate mode.
module radix4_seq_mult
  import radix4_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               out_approx
);

  localparam int N  = num_digits(WIDTH);
  localparam int AW = acc_width(WIDTH);
  localparam int IW = $clog2(N);

  state_t            state, state_nxt;
  logic [IW-1:0]     cnt;
  logic [WIDTH-1:0]  x_r, y_r;
  logic              approx_r;
  logic [AW-1:0]     acc;
  logic [AW-1:0]     term;
  logic [WIDTH+2:0]  y_ext;
  logic signed [2:0] digit;
  logic              accept, last;
  logic              unused_acc_top;

  // Zero below bit 0 and two zeros above the MSB make the top digit 0 or +1.
  assign y_ext  = {2'b00, y_r, 1'b0};
  assign digit  = booth_digit(y_ext[{cnt, 1'b0} +: 3]);
  assign accept = in_valid && in_ready;
  assign last   = (cnt == IW'(N - 1));

  radix4_booth_pp #(
    .WIDTH       (WIDTH),
    .APPROX_BITS (APPROX_BITS)
  ) u_pp (
    .x      (x_r),
    .digit  (digit),
    .idx    (cnt),
    .approx (approx_r),
    .term   (term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      x_r      <= '0;
      y_r      <= '0;
      approx_r <= 1'b0;
      acc      <= '0;
    end else if (accept) begin
      cnt      <= '0;
      x_r      <= x;
      y_r      <= y;
      approx_r <= approx;
      acc      <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + IW'(1);
      acc <= acc + term;
    end
  end

  // The guard bits only keep the running sum exact; the product is the low half.
  assign p              = acc[2*WIDTH-1:0];
  assign unused_acc_top = ^acc[AW-1:2*WIDTH];
  assign out_approx     = approx_r;

endmodule

// File: tb/tb_radix4_seq_mult.sv
// Directed bench for radix4_seq_mult at 8/4 and 16/6 with hand-computed
// products plus seeded vectors checked against an arithmetic Booth model.
module tb_radix4_seq_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_in_valid, a_in_ready, a_approx, a_out_valid, a_out_ready, a_out_approx;
  logic [7:0]  a_x, a_y;
  logic [15:0] a_p;
  logic        b_in_valid, b_in_ready, b_approx, b_out_valid, b_out_ready, b_out_approx;
  logic [15:0] b_x, b_y;
  logic [31:0] b_p;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  radix4_seq_mult #(.WIDTH(8), .APPROX_BITS(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .y(a_y), .approx(a_approx), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .p(a_p), .out_approx(a_out_approx)
  );

  radix4_seq_mult #(.WIDTH(16), .APPROX_BITS(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .y(b_y), .approx(b_approx), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .p(b_p), .out_approx(b_out_approx)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Sum of d_i*x*4^i in signed arithmetic, masked, reduced to 2w bits.
  function automatic longint model(input int w, input int ab, input longint xv,
                                   input longint yv, input bit ap);
    longint acc, t, yext;
    int b, d;
    acc  = 0;
    yext = yv << 1;
    for (int i = 0; i < w / 2 + 1; i++) begin
      b = int'((yext >> (2 * i)) & 7);
      d = -2 * ((b >> 2) & 1) + ((b >> 1) & 1) + (b & 1);
      t = longint'(d) * xv * (longint'(1) << (2 * i));
      if (ap) t = t & ~((longint'(1) << ab) - 1);
      acc += t;
    end
    return acc & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic xact(input bit wide, input logic [15:0] xv, input logic [15:0] yv,
                      input bit ap, output logic [31:0] pv, output logic oa,
                      output int lat);
    @(negedge clk);
    if (wide) begin
      b_x = xv; b_y = yv; b_approx = ap; b_in_valid = 1'b1;
    end else begin
      a_x = xv[7:0]; a_y = yv[7:0]; a_approx = ap; a_in_valid = 1'b1;
    end
    chk("in_ready_at_accept", wide ? b_in_ready : a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 1;
    while (!(wide ? b_out_valid : a_out_valid) && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("out_valid_timeout", lat < 64, 1);
    pv = wide ? b_p : {16'h0, a_p};
    oa = wide ? b_out_approx : a_out_approx;
    chk("in_ready_while_done", wide ? b_in_ready : a_in_ready, 0);
    if (wide) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    chk("out_valid_after_retire", wide ? b_out_valid : a_out_valid, 0);
    chk("in_ready_after_retire", wide ? b_in_ready : a_in_ready, 1);
  endtask

  logic [31:0] pv;
  logic        oa;
  int          lat;
  logic [15:0] rx, ry;
  logic [7:0]  cx [5] = '{8'd0, 8'd255, 8'd1, 8'd170, 8'd255};
  logic [7:0]  cy [5] = '{8'd255, 8'd0, 8'd1, 8'd85, 8'd255};

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_approx = 0; a_out_ready = 0; a_x = 0; a_y = 0;
    b_in_valid = 0; b_approx = 0; b_out_ready = 0; b_x = 0; b_y = 0;
    rx = 16'($urandom(32'h5eed_0042));

    // Reset held with inputs toggling
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      a_in_valid = ~a_in_valid; a_x = 8'($urandom); a_y = 8'($urandom); a_approx = ~a_approx;
      b_in_valid = ~b_in_valid; a_out_ready = ~a_out_ready;
      #1;
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_p", a_p, 0);
      chk("rst_out_approx", a_out_approx, 0);
      chk("rst_out_valid16", b_out_valid, 0);
    end
    a_in_valid = 0; b_in_valid = 0; a_out_ready = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Exact maximum
    xact(0, 255, 255, 0, pv, oa, lat);
    chk("max_latency", lat, 6);
    chk("max_p", pv, 65025);
    chk("max_out_approx", oa, 0);

    // Approximate vs exact on 200*3
    xact(0, 200, 3, 1, pv, oa, lat);
    chk("approx_p", pv, 592);
    chk("approx_out_approx", oa, 1);
    xact(0, 200, 3, 0, pv, oa, lat);
    chk("exact_200x3", pv, 600);

    // Back-pressure with ignored input pulses
    @(negedge clk);
    a_x = 17; a_y = 9; a_approx = 0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 6);
    for (int c = 0; c < 10; c++) begin
      a_x = 1; a_y = 1; a_in_valid = c[0];
      @(negedge clk);
      chk("bp_p_stable", a_p, 153);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_in_ready", a_in_ready, 0);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b0;
    chk("bp_retired_valid", a_out_valid, 0);
    chk("bp_retired_in_ready", a_in_ready, 1);
    chk("bp_retired_p", a_p, 153);
    repeat (8) @(negedge clk);
    chk("bp_no_ghost_result", a_out_valid, 0);

    // Reset two edges after an accept
    @(negedge clk);
    a_x = 100; a_y = 100; a_approx = 1; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_p", a_p, 0);
    chk("midrst_out_approx", a_out_approx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_stale_valid", a_out_valid, 0);
    xact(0, 3, 5, 0, pv, oa, lat);
    chk("midrst_next_p", pv, 15);
    chk("midrst_next_latency", lat, 6);

    // Corners in both modes
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 5; k++) begin
        xact(0, {8'h0, cx[k]}, {8'h0, cy[k]}, m[0], pv, oa, lat);
        chk("corner8_p", pv, model(8, 4, cx[k], cy[k], m[0]));
        chk("corner8_out_approx", oa, m[0]);
      end
    xact(0, 170, 85, 0, pv, oa, lat);
    chk("exact_170x85", pv, 14450);

    // 16-bit instance
    xact(1, 16'hFFFF, 16'hFFFF, 0, pv, oa, lat);
    chk("w16_max_p", pv, 32'd4294836225);
    chk("w16_latency", lat, 10);
    xact(1, 1000, 3, 1, pv, oa, lat);
    chk("w16_approx_p", pv, 2944);
    chk("w16_approx_echo", oa, 1);
    xact(1, 1000, 3, 0, pv, oa, lat);
    chk("w16_exact_p", pv, 3000);
    xact(1, 16'hFFFF, 16'hFFFF, 1, pv, oa, lat);
    chk("w16_approx_max", pv, model(16, 6, 65535, 65535, 1));

    // Seeded vectors per mode and width
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < 50; k++) begin
        rx = 16'($urandom_range(0, 255));
        ry = 16'($urandom_range(0, 255));
        xact(0, rx, ry, m[0], pv, oa, lat);
        chk("rand8_p", pv, model(8, 4, rx, ry, m[0]));
        chk("rand8_out_approx", oa, m[0]);
        chk("rand8_latency", lat, 6);
        rx = 16'($urandom_range(0, 65535));
        ry = 16'($urandom_range(0, 65535));
        xact(1, rx, ry, m[0], pv, oa, lat);
        chk("rand16_p", pv, model(16, 6, rx, ry, m[0]));
        chk("rand16_out_approx", oa, m[0]);
      end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/radix4_seq_mult.md
# radix4_seq_mult

Parametrised, multi-cycle radix-4 Booth multiplier for unsigned operands, with a per-transaction exact/approximate mode. It is the sequential successor to the combinational 8×8 radix-4 approximate multiplier. It retires one Booth digit per clock, which trades latency for area. It sits behind valid/ready handshakes so it can be dropped between a stimulus source and a result sink.

## Interface
- `WIDTH`, default 8: operand width in bits; even, ≥ 4.
- `APPROX_BITS`, default 4: in approximate mode, the number of low result-weight bits zeroed in every partial product; 0 ≤ `APPROX_BITS` < 2·`WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  block can accept a new operand pair.
- `x`  in  `WIDTH`  multiplicand, unsigned.
- `y`  in  `WIDTH`  multiplier, unsigned; Booth-recoded.
- `approx`  in  1  1 selects approximate mode for this transaction.
- `out_valid`  out  1  `p` holds a finished product.
- `out_ready`  in  1  sink accepts `p`.
- `p`  out  2·`WIDTH`  product.
- `out_approx`  out  1  echo of `approx` for the transaction now in `p`.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1.
  - BUSY: digit counter runs from 0 to N−1, where N = `WIDTH`/2+1 (N=5 for `WIDTH`=8).
  - DONE: `out_valid`=1.
- IDLE→BUSY when `in_valid`&&`in_ready`. On that edge:
  - `x`, `y` and `approx` are registered.
  - The accumulator is cleared.
  - The counter is set to 0.
- BUSY: each edge adds term T_i for i = counter, then increments the counter. After the edge with counter = N−1, the block moves to DONE.
- DONE→IDLE on `out_valid`&&`out_ready`.
- Inputs are ignored outside IDLE.
- Recoding:
  - Extend y with a 0 below bit 0 and two 0s above bit `WIDTH`−1.
  - Digit d_i = −2·y[2i+1] + y[2i] + y[2i−1], giving d_i ∈ {−2,−1,0,1,2}.
  - The top digit d_{N−1} ∈ {0,1}, so unsigned operands need no correction term.
- Term T_i = d_i·x·4^i, held as a 2·`WIDTH`+2-bit two's-complement value.
- Approximate mode:
  - T_i' = T_i with bits [`APPROX_BITS`−1:0] forced to 0. Masking is applied to the two's-complement pattern.
  - Exact mode: T_i' = T_i.
- Accumulator is 2·`WIDTH`+2 bits and wraps modulo its width.
- `p` = accumulator[2·`WIDTH`−1:0].
  - In exact mode this equals x·y.
  - In approximate mode the modulo result is still defined.
- `approx`=1 with `APPROX_BITS`=0 gives the exact result.

## Timing
- Reset values:
  - `in_ready`=1 (state IDLE); `out_valid`=0, `p`=0, `out_approx`=0.
  - Accumulator, counter and operand registers all 0.
- Latency: `out_valid` rises N+1 edges after the accept edge (one accept edge plus N BUSY edges).
- Throughput: at best one product per N+2 cycles.
- `p` and `out_approx` are registered. They are stable for the whole DONE interval, whatever `out_ready` does.
- `out_ready` high on the cycle DONE is entered: the handshake completes on the next edge, then IDLE with `in_ready`=1.
- `in_ready` is never 1 in the same cycle as `out_valid`. There is no accept/retire overlap.
- `rst_n` low in any state, including mid-BUSY:
  - Aborts immediately and asynchronously, returning all outputs to their reset values.
  - The partial result is discarded and no `out_valid` is produced for it.
  - After `rst_n` deasserts, the first accept is possible on the first edge.

## Structure
- Package `radix4_pkg`:
  - State enum (IDLE/BUSY/DONE).
  - Function `booth_digit(bits[2:0])` returning a 3-bit signed digit.
  - Localparam-style helpers: N and accumulator width.
- Sub-module `radix4_booth_pp`:
  - Combinational.
  - Inputs: x, digit, shift index, approx, `APPROX_BITS`.
  - Output: T_i'.
- The top level holds the FSM, counter, operand registers and accumulator.

## Test plan
- Reset: hold `rst_n`=0 → `in_ready`=1, `out_valid`=0, `p`=0; inputs toggling have no effect.
- Exact max: x=255, y=255, approx=0, `out_ready`=1 → `out_valid` exactly 6 edges after accept, `p`=65025, `out_approx`=0; `in_ready`=1 one cycle later.
- Approximate: x=200, y=3, approx=1, `APPROX_BITS`=4:
  - Terms: T0 = −200 → −208; T1 = 800 → 800.
  - Expected `p`=592 and `out_approx`=1; exact mode on the same operands gives 600.
- Back-pressure: complete x=17, y=9 with `out_ready`=0 for 10 cycles.
  - Throughout: `p`=153 stable, `out_valid`=1, `in_ready`=0.
  - Pulsing `in_valid` with x=1, y=1 during this interval is ignored.
  - Raising `out_ready` retires 153 only.
- Mid-operation reset: assert `rst_n`=0 two edges after accepting x=100, y=100.
  - Outputs go to reset values at once.
  - After release, x=3, y=5 yields `p`=15 with no stale result.
- Random: 50 seeded vectors per mode plus corners (0×255, 255×0, 1×1, 170×85), checked against a bit-accurate model of T_i' summation. Repeat at `WIDTH`=16, `APPROX_BITS`=6.
